pu_program_loader: RTL and testbench

PU_PROGRAM_LOADER -- requirements
Module: pu_program_loader

---
 rtl/pu_program_loader_pkg.sv | 20 ++
 rtl/pu_program_loader_packer.sv | 51 +++++
 rtl/pu_program_loader.sv | 147 ++++++++++++++
 tb/tb_pu_program_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, frame length-field width, bytes-per-word.
// Optional checksum stage is compiled in with PU_PROGRAM_LOADER_CHECKSUM_EN.
package pu_program_loader_pkg;

  localparam int LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  function automatic int calc_bpw(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pu_program_loader_packer.sv
// Assembles program words from a byte stream, least-significant byte first.
// word/word_done are valid combinationally on the cycle the final byte is taken.
module pu_program_loader_packer
  import pu_program_loader_pkg::*;
#(
  parameter int MICROCODE_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       take,
  input  logic [7:0]                 in_byte,
  output logic [MICROCODE_WIDTH-1:0] word,
  output logic                       word_done
);

  localparam int BPW = calc_bpw(MICROCODE_WIDTH);
  localparam int SW  = BPW * 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [SW-1:0] shift_q;
  logic [SW-1:0] shift_next;
  logic [CW-1:0] cnt_q;
  logic          last_byte;

  // New bytes enter at the top so the first byte ends up in the low lane.
  generate
    if (BPW == 1) begin : g_single
      assign shift_next = in_byte;
    end else begin : g_multi
      assign shift_next = {in_byte, shift_q[SW-1:8]};
    end
  endgenerate

  assign last_byte = (cnt_q == CW'(BPW - 1));
  assign word_done = take && last_byte;
  assign word      = shift_next[MICROCODE_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (take) begin
      shift_q <= shift_next;
      cnt_q   <= last_byte ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pu_program_loader.sv
// Loads a length-prefixed byte frame into program memory; busy holds the sequencer in reset.
// Define PU_PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module pu_program_loader
  import pu_program_loader_pkg::*;
#(
  parameter int MICROCODE_WIDTH = 16,
  parameter int PROGRAM_SIZE    = 200,
  parameter int ADDR_WIDTH      = $clog2(PROGRAM_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       clear,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [MICROCODE_WIDTH-1:0] mem_data,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_error,
  output state_e                     dbg_state
);

  // Handshake: a byte transfers on any rising edge with in_valid && in_ready;
  // in_ready is tied high so the stream never stalls, even in ERROR.
  state_e                     state;
  logic [7:0]                 len_lo;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [LEN_WIDTH-1:0]       word_cnt;
  logic [LEN_WIDTH-1:0]       len_n;
  logic                       take;
  logic                       pack_done;
  logic [MICROCODE_WIDTH-1:0] pack_word;
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]                 xor_q;
`endif

  assign in_ready  = 1'b1;
  assign take      = in_valid && in_ready;
  assign len_n     = {in_data, len_lo};
  assign dbg_state = state;

  pu_program_loader_packer #(
    .MICROCODE_WIDTH(MICROCODE_WIDTH)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != ST_DATA),
    .take     (take && (state == ST_DATA)),
    .in_byte  (in_data),
    .word     (pack_word),
    .word_done(pack_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      len_q      <= '0;
      word_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        ST_IDLE: if (take) begin
          len_lo <= in_data;
          busy   <= 1'b1;
          state  <= ST_LEN_HI;
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
          xor_q  <= in_data;
`endif
        end
        ST_LEN_HI: if (take) begin
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
          xor_q <= xor_q ^ in_data;
`endif
          if (int'(len_n) > PROGRAM_SIZE) begin
            busy       <= 1'b0;
            load_error <= 1'b1;
            state      <= ST_ERROR;
          end else if (len_n == '0) begin
            busy      <= 1'b0;
            load_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            len_q    <= len_n;
            word_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: if (take) begin
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
          xor_q <= xor_q ^ in_data;
`endif
          if (pack_done) begin
            mem_we   <= 1'b1;
            mem_addr <= word_cnt[ADDR_WIDTH-1:0];
            mem_data <= pack_word;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == len_q - 1'b1) begin
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
              state <= ST_CHECK;
`else
              busy      <= 1'b0;
              load_done <= 1'b1;
              state     <= ST_IDLE;
`endif
            end
          end
        end
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK: if (take) begin
          busy <= 1'b0;
          if (in_data == xor_q) begin
            load_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            load_error <= 1'b1;
            state      <= ST_ERROR;
          end
        end
`endif
        ST_ERROR: if (clear) begin
          load_error <= 1'b0;
          state      <= ST_IDLE;
        end
        // LEN_LO is reserved and CHECK is unreachable without the checksum stage.
        default: begin
          busy       <= 1'b0;
          load_error <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_program_loader.sv
// Bench for pu_program_loader: a 16-bit instance and a 12-bit instance share clock and reset.
// Frames carry a checksum byte when PU_PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_pu_program_loader;
  import pu_program_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a_in_data, b_in_data;
  logic        a_in_valid, b_in_valid, a_clear, b_clear;
  logic        a_in_ready, b_in_ready;
  logic        a_mem_we, b_mem_we;
  logic [7:0]  a_mem_addr, b_mem_addr;
  logic [15:0] a_mem_data;
  logic [11:0] b_mem_data;
  logic        a_busy, b_busy, a_load_done, b_load_done, a_load_error, b_load_error;
  state_e      a_state, b_state;

  pu_program_loader dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .clear(a_clear), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .busy(a_busy), .load_done(a_load_done), .load_error(a_load_error), .dbg_state(a_state)
  );

  pu_program_loader #(.MICROCODE_WIDTH(12), .PROGRAM_SIZE(200)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .clear(b_clear), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .busy(b_busy), .load_done(b_load_done), .load_error(b_load_error), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_a_q[$];
  logic [19:0] exp_b_q[$];
  logic [23:0] a_exp;
  logic [19:0] b_exp;
  int a_we_cnt = 0, a_done_cnt = 0, b_we_cnt = 0, b_done_cnt = 0;
  logic a_done_with_we = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_mem_we) begin
        a_we_cnt++;
        n_tests++;
        if (exp_a_q.size() == 0) begin
          n_fail++;
          $display("FAIL a_write: unexpected addr=%0h data=%0h, required no write", a_mem_addr, a_mem_data);
        end else begin
          a_exp = exp_a_q.pop_front();
          if ({a_mem_addr, a_mem_data} !== a_exp) begin
            n_fail++;
            $display("FAIL a_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     a_mem_addr, a_mem_data, a_exp[23:16], a_exp[15:0]);
          end
        end
      end
      if (a_load_done) begin
        a_done_cnt++;
        a_done_with_we = a_mem_we;
      end
      if (b_mem_we) begin
        b_we_cnt++;
        n_tests++;
        if (exp_b_q.size() == 0) begin
          n_fail++;
          $display("FAIL b_write: unexpected addr=%0h data=%0h, required no write", b_mem_addr, b_mem_data);
        end else begin
          b_exp = exp_b_q.pop_front();
          if ({b_mem_addr, b_mem_data} !== b_exp) begin
            n_fail++;
            $display("FAIL b_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     b_mem_addr, b_mem_data, b_exp[19:12], b_exp[11:0]);
          end
        end
      end
      if (b_load_done) b_done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    a_in_data = b; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_in_data = b; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic frame_a(input logic [15:0] words[$]);
    logic [15:0] n;
    logic [7:0]  cs;
    n  = 16'(words.size());
    cs = n[7:0] ^ n[15:8];
    send_a(n[7:0]);
    send_a(n[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      exp_a_q.push_back({8'(i), words[i]});
      cs = cs ^ words[i][7:0] ^ words[i][15:8];
      send_a(words[i][7:0]);
      send_a(words[i][15:8]);
    end
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
    if (n != 0) send_a(cs);
`endif
  endtask

  // 12-bit frames with random idle gaps between bytes
  task automatic frame_b(input logic [11:0] words[$]);
    logic [15:0] n;
    logic [7:0]  cs;
    logic [7:0]  bytes[$];
    n = 16'(words.size());
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      exp_b_q.push_back({8'(i), words[i]});
      bytes.push_back(words[i][7:0]);
      bytes.push_back({4'h0, words[i][11:8]});
    end
    cs = 8'h00;
    foreach (bytes[i]) cs = cs ^ bytes[i];
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
    bytes.push_back(cs);
`endif
    foreach (bytes[i]) begin
      send_b(bytes[i]);
      tick($urandom_range(0, 2));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_tests++;
    if ({a_mem_we, a_mem_addr, a_mem_data, a_busy, a_load_done, a_load_error, a_in_ready} !==
        {1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_a_outputs: got we=%b addr=%0h data=%0h busy=%b done=%b err=%b rdy=%b, required 0 0 0 0 0 0 1",
               a_mem_we, a_mem_addr, a_mem_data, a_busy, a_load_done, a_load_error, a_in_ready);
    end
    n_tests++;
    if (a_state !== ST_IDLE || b_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got a=%0d b=%0d, required %0d", a_state, b_state, ST_IDLE);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_load();
    int w0, d0;
    w0 = a_we_cnt; d0 = a_done_cnt;
    a_clear = 1'b1;
    exp_a_q.push_back({8'd0, 16'h1234});
    exp_a_q.push_back({8'd1, 16'h5678});
    send_a(8'h02);
    n_tests++;
    if (a_busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got %b, required 1", a_busy);
    end
    send_a(8'h00); send_a(8'h34); send_a(8'h12); send_a(8'h78); send_a(8'h56);
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
    send_a(8'h0A);
`endif
    a_clear = 1'b0;
    tick(3);
    n_tests++;
    if (a_we_cnt - w0 != 2 || exp_a_q.size() != 0) begin
      n_fail++; $display("FAIL basic_writes: got %0d writes, %0d pending, required 2 and 0", a_we_cnt - w0, exp_a_q.size());
    end
    n_tests++;
    if (a_done_cnt - d0 != 1 || a_busy !== 1'b0 || a_load_error !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got done=%0d busy=%b err=%b, required 1 0 0", a_done_cnt - d0, a_busy, a_load_error);
    end
`ifndef PU_PROGRAM_LOADER_CHECKSUM_EN
    n_tests++;
    if (a_done_with_we !== 1'b1) begin
      n_fail++; $display("FAIL basic_done_align: mem_we at load_done=%b, required 1", a_done_with_we);
    end
`endif
  endtask

  task automatic test_oversize();
    logic [15:0] q[$];
    int w0, d0;
    w0 = a_we_cnt; d0 = a_done_cnt;
    send_a(8'hC9); send_a(8'h00);
    n_tests++;
    if (a_load_error !== 1'b1 || a_busy !== 1'b0 || a_state !== ST_ERROR) begin
      n_fail++; $display("FAIL oversize_error: got err=%b busy=%b state=%0d, required 1 0 %0d", a_load_error, a_busy, a_state, ST_ERROR);
    end
    send_a(8'h01); send_a(8'h00); send_a(8'h34); send_a(8'h12);
    tick(2);
    n_tests++;
    if (a_we_cnt != w0 || a_load_error !== 1'b1) begin
      n_fail++; $display("FAIL oversize_discard: got %0d writes err=%b, required 0 writes err=1", a_we_cnt - w0, a_load_error);
    end
    a_clear = 1'b1;
    tick(1);
    a_clear = 1'b0;
    n_tests++;
    if (a_load_error !== 1'b0 || a_state !== ST_IDLE) begin
      n_fail++; $display("FAIL oversize_clear: got err=%b state=%0d, required 0 %0d", a_load_error, a_state, ST_IDLE);
    end
    q.push_back(16'hBEEF);
    frame_a(q);
    tick(3);
    n_tests++;
    if (a_we_cnt - w0 != 1 || exp_a_q.size() != 0 || a_done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL oversize_reload: got writes=%0d done=%0d, required 1 1", a_we_cnt - w0, a_done_cnt - d0);
    end
  endtask

  task automatic test_zero_len();
    int w0, d0;
    w0 = a_we_cnt; d0 = a_done_cnt;
    send_a(8'h00); send_a(8'h00);
    tick(3);
    n_tests++;
    if (a_we_cnt != w0 || a_done_cnt - d0 != 1 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_len: got writes=%0d done=%0d busy=%b, required 0 1 0", a_we_cnt - w0, a_done_cnt - d0, a_busy);
    end
  endtask

`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int d0;
    d0 = a_done_cnt;
    exp_a_q.push_back({8'd0, 16'hABCD});
    send_a(8'h01); send_a(8'h00); send_a(8'hCD); send_a(8'hAB); send_a(8'h67);
    tick(3);
    n_tests++;
    if (a_done_cnt - d0 != 1 || a_load_error !== 1'b0) begin
      n_fail++; $display("FAIL checksum_good: got done=%0d err=%b, required 1 0", a_done_cnt - d0, a_load_error);
    end
    exp_a_q.push_back({8'd0, 16'hABCD});
    send_a(8'h01); send_a(8'h00); send_a(8'hCD); send_a(8'hAB); send_a(8'h00);
    tick(3);
    n_tests++;
    if (a_done_cnt - d0 != 1 || a_load_error !== 1'b1 || exp_a_q.size() != 0) begin
      n_fail++; $display("FAIL checksum_bad: got done=%0d err=%b pending=%0d, required 1 1 0", a_done_cnt - d0, a_load_error, exp_a_q.size());
    end
    a_clear = 1'b1;
    tick(1);
    a_clear = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [15:0] q[$];
    int w0;
    w0 = a_we_cnt;
    send_a(8'h02); send_a(8'h00); send_a(8'h34);
    n_tests++;
    if (a_busy !== 1'b1 || a_state !== ST_DATA) begin
      n_fail++; $display("FAIL midrst_pre: got busy=%b state=%0d, required 1 %0d", a_busy, a_state, ST_DATA);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({a_mem_we, a_mem_addr, a_mem_data, a_busy, a_load_done, a_load_error} !== 27'h0 || a_state !== ST_IDLE) begin
      n_fail++; $display("FAIL midrst_outputs: got we=%b addr=%0h data=%0h busy=%b done=%b err=%b state=%0d, required all 0 idle",
                         a_mem_we, a_mem_addr, a_mem_data, a_busy, a_load_done, a_load_error, a_state);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    q.push_back(16'h2211);
    frame_a(q);
    tick(3);
    n_tests++;
    if (a_we_cnt - w0 != 1 || exp_a_q.size() != 0) begin
      n_fail++; $display("FAIL midrst_reload: got writes=%0d pending=%0d, required 1 0", a_we_cnt - w0, exp_a_q.size());
    end
  endtask

  task automatic test_width12();
    logic [11:0] q[$];
    int w0, d0;
    w0 = b_we_cnt; d0 = b_done_cnt;
    q.push_back(12'hABC);
    frame_b(q);
    tick(3);
    n_tests++;
    if (b_we_cnt - w0 != 1 || b_done_cnt - d0 != 1 || exp_b_q.size() != 0) begin
      n_fail++; $display("FAIL width12_single: got writes=%0d done=%0d, required 1 1", b_we_cnt - w0, b_done_cnt - d0);
    end
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(12'($urandom_range(0, 4095)));
    frame_b(q);
    tick(3);
    n_tests++;
    if (b_we_cnt - w0 != 4 || b_done_cnt - d0 != 2 || exp_b_q.size() != 0) begin
      n_fail++; $display("FAIL width12_multi: got writes=%0d done=%0d, required 4 2", b_we_cnt - w0, b_done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    int w0, d0;
    w0 = a_we_cnt; d0 = a_done_cnt;
    for (int i = 0; i < 3; i++) q1.push_back(16'($urandom_range(0, 65535)));
    q2.push_back(16'($urandom_range(0, 65535)));
    frame_a(q1);
    frame_a(q2);
    tick(3);
    n_tests++;
    if (a_we_cnt - w0 != 4 || a_done_cnt - d0 != 2 || exp_a_q.size() != 0) begin
      n_fail++; $display("FAIL back_to_back: got writes=%0d done=%0d, required 4 2", a_we_cnt - w0, a_done_cnt - d0);
    end
  endtask

  task automatic test_max_len();
    logic [15:0] q[$];
    int w0, d0;
    w0 = a_we_cnt; d0 = a_done_cnt;
    for (int i = 0; i < 200; i++) q.push_back(16'($urandom_range(0, 65535)));
    frame_a(q);
    tick(3);
    n_tests++;
    if (a_we_cnt - w0 != 200 || a_done_cnt - d0 != 1 || a_load_error !== 1'b0) begin
      n_fail++; $display("FAIL max_len: got writes=%0d done=%0d err=%b, required 200 1 0", a_we_cnt - w0, a_done_cnt - d0, a_load_error);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    a_in_data = 8'h00; a_in_valid = 1'b0; a_clear = 1'b0;
    b_in_data = 8'h00; b_in_valid = 1'b0; b_clear = 1'b0;
    test_reset();
    test_basic_load();
    test_oversize();
    test_zero_len();
`ifdef PU_PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_frame();
    test_width12();
    test_back_to_back();
    test_max_len();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
